// File: rtl/timed_task_scheduler_if.sv
// Launch / completion / join handshake bundle between a task-issuing master
// and the timed task scheduler.
interface timed_task_scheduler_if #(
  parameter int DELAY_W = 8,
  parameter int ID_W    = 4
);
  logic               launch_valid;
  logic               launch_ready;
  logic [DELAY_W-1:0] launch_delay;
  logic [ID_W-1:0]    launch_id;
  logic               done_valid;
  logic               done_ready;
  logic [ID_W-1:0]    done_id;
  logic [DELAY_W-1:0] done_delay;
  logic               join_req;
  logic               join_ack;

  modport master (
    output launch_valid, launch_delay, launch_id, done_ready, join_req,
    input  launch_ready, done_valid, done_id, done_delay, join_ack
  );

  modport slave (
    input  launch_valid, launch_delay, launch_id, done_ready, join_req,
    output launch_ready, done_valid, done_id, done_delay, join_ack
  );
endinterface

// File: rtl/timed_task_scheduler.sv
// Timer-slot task scheduler: launches delayed tasks, reports each expiry once,
// and acknowledges a join only after every outstanding task has drained.
module timed_task_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int DELAY_W   = 8,
  parameter int ID_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  timed_task_scheduler_if.slave          bus,
  output logic [$clog2(NUM_SLOTS+1)-1:0] busy_count
);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  typedef enum logic {IDLE, JOINING} state_t;

  state_t             state_q, state_d;
  logic [NUM_SLOTS-1:0] busy_q;
  logic [DELAY_W-1:0] count_q [NUM_SLOTS];
  logic [ID_W-1:0]    id_q    [NUM_SLOTS];
  logic [DELAY_W-1:0] orig_q  [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] expired, free_sel, exp_sel;
  logic launch_fire, done_fire;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++)
      expired[i] = busy_q[i] && (count_q[i] == '0);
  end

  // One-hot picks of the lowest free slot and the lowest expired slot.
  always_comb begin
    free_sel = '0;
    exp_sel  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!busy_q[i] && (free_sel == '0)) free_sel[i] = 1'b1;
      if (expired[i] && (exp_sel == '0))  exp_sel[i]  = 1'b1;
    end
  end

  always_comb begin
    bus.done_id    = '0;
    bus.done_delay = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (exp_sel[i]) begin
        bus.done_id    = id_q[i];
        bus.done_delay = orig_q[i];
      end
    end
  end

  always_comb begin
    busy_count = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++)
      busy_count = busy_count + CNT_W'(busy_q[i]);
  end

  assign bus.done_valid   = |expired;
  assign bus.launch_ready = (|(~busy_q)) && (state_q == IDLE);
  assign launch_fire      = bus.launch_valid && bus.launch_ready;
  assign done_fire        = bus.done_valid && bus.done_ready;

  // The freed slot is always busy and the launch target always free, so the
  // free and the allocation can never hit the same slot at one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        count_q[i] <= '0;
        id_q[i]    <= '0;
        orig_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (busy_q[i] && (count_q[i] != '0))
          count_q[i] <= count_q[i] - DELAY_W'(1);
        if (done_fire && exp_sel[i])
          busy_q[i] <= 1'b0;
        if (launch_fire && free_sel[i]) begin
          busy_q[i]  <= 1'b1;
          count_q[i] <= bus.launch_delay;
          id_q[i]    <= bus.launch_id;
          orig_q[i]  <= bus.launch_delay;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.join_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.join_req) state_d = JOINING;
      end
      JOINING: begin
        if (busy_count == '0) begin
          bus.join_ack = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_timed_task_scheduler.sv
// Randomized + directed bench for timed_task_scheduler, checked every cycle
// against an absolute-expiry-time reference model through a scoreboard queue.
module tb_timed_task_scheduler;
  localparam int NS = 8;
  localparam int DW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(NS+1)-1:0] busy_count;

  timed_task_scheduler_if #(.DELAY_W(DW), .ID_W(IW)) bus ();

  timed_task_scheduler #(.NUM_SLOTS(NS), .DELAY_W(DW), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp, input int cyc);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: each task holds its absolute expiry cycle.
  typedef struct {
    int cyc;
    int ready;
    int busy;
    int dv;
    int id;
    int dly;
    int ack;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cur_slot;
  bit   m_busy [NS];
  int   m_exp  [NS];
  int   m_id   [NS];
  int   m_dly  [NS];
  bit   m_join;
  int   edge_n = 0;

  function automatic void compute();
    int nfree;
    nfree = 0;
    cur = '{cyc: edge_n, ready: 0, busy: 0, dv: 0, id: 0, dly: 0, ack: 0};
    cur_slot = -1;
    for (int i = 0; i < NS; i++) begin
      if (m_busy[i]) cur.busy++;
      else nfree++;
      if (m_busy[i] && edge_n >= m_exp[i] && cur_slot < 0) cur_slot = i;
    end
    cur.ready = (nfree > 0 && !m_join) ? 1 : 0;
    cur.ack   = (m_join && cur.busy == 0) ? 1 : 0;
    if (cur_slot >= 0) begin
      cur.dv  = 1;
      cur.id  = m_id[cur_slot];
      cur.dly = m_dly[cur_slot];
    end
  endfunction

  always @(posedge clk) begin
    int fi;
    edge_n++;
    if (rst) begin
      for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
      m_join = 1'b0;
    end else begin
      fi = -1;
      for (int i = 0; i < NS; i++)
        if (!m_busy[i] && fi < 0) fi = i;
      if (cur.dv != 0 && bus.done_ready) m_busy[cur_slot] = 1'b0;
      if (bus.launch_valid && cur.ready != 0) begin
        m_busy[fi] = 1'b1;
        m_exp[fi]  = edge_n + int'(bus.launch_delay);
        m_id[fi]   = int'(bus.launch_id);
        m_dly[fi]  = int'(bus.launch_delay);
      end
      if (!m_join) m_join = bus.join_req;
      else if (cur.ack != 0) m_join = 1'b0;
    end
    compute();
    exp_q.push_back(cur);
  end

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("launch_ready", int'(bus.launch_ready), e.ready, e.cyc);
      chk("busy_count",   int'(busy_count),       e.busy,  e.cyc);
      chk("done_valid",   int'(bus.done_valid),   e.dv,    e.cyc);
      chk("done_id",      int'(bus.done_id),      e.id,    e.cyc);
      chk("done_delay",   int'(bus.done_delay),   e.dly,   e.cyc);
      chk("join_ack",     int'(bus.join_ack),     e.ack,   e.cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input int id, input int d);
    bit r;
    bit ok;
    ok = 1'b0;
    bus.launch_valid = 1'b1;
    bus.launch_id    = IW'(id);
    bus.launch_delay = DW'(d);
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      r = bus.launch_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    bus.launch_valid = 1'b0;
    if (!ok) chk("launch_timeout", 0, 1, edge_n);
  endtask

  task automatic join_pulse();
    bus.join_req = 1'b1;
    step(1);
    bus.join_req = 1'b0;
  endtask

  task automatic drain(input int maxc);
    bus.done_ready = 1'b1;
    for (int i = 0; i < maxc && busy_count != 0; i++) step(1);
    chk("drain_timeout", int'(busy_count), 0, edge_n);
    step(2);
  endtask

  initial begin
    rst = 1'b1;
    bus.launch_valid = 1'b0;
    bus.launch_delay = '0;
    bus.launch_id    = '0;
    bus.done_ready   = 1'b0;
    bus.join_req     = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    // Staggered delays complete in reverse launch order.
    bus.done_ready = 1'b1;
    launch(1, 30); launch(2, 17); launch(3, 10); launch(4, 5); launch(5, 1);
    drain(60);

    // Zero-delay tasks followed immediately by a join.
    launch(6, 0); launch(7, 0); launch(8, 0);
    join_pulse();
    step(8);

    // Fill every slot, hold backpressure, then release.
    bus.done_ready = 1'b0;
    for (int i = 0; i < NS; i++) launch(i + 1, 20);
    step(30);
    drain(40);

    // Join with nothing outstanding.
    join_pulse();
    step(3);

    // Reset discards long and short tasks before they expire.
    launch(9, 255); launch(10, 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(270);

    // Slots 0 and 2 expiring on the same cycle.
    bus.done_ready = 1'b1;
    launch(11, 12); launch(12, 60); launch(13, 10);
    drain(80);

    // Randomized traffic with backpressure and joins.
    for (int c = 0; c < 500; c++) begin
      bus.launch_valid = ($urandom_range(0, 2) == 0);
      bus.launch_delay = DW'($urandom_range(0, 40));
      bus.launch_id    = IW'($urandom);
      bus.done_ready   = ($urandom_range(0, 9) < 7);
      bus.join_req     = ($urandom_range(0, 29) == 0);
      step(1);
    end
    bus.launch_valid = 1'b0;
    bus.join_req     = 1'b0;
    drain(200);
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
